dmem_responder: RTL and testbench

//  Data-memory responder for the cpu's DMEM port: serves DM_ena/DM_R/DM_W/DM_sel, with ALU_OUT as byte address.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Byte-lane data memory responder for the cpu DMEM port, with optional wait-state handshake.
// Define DMEM_MISALIGN_EN to flag misaligned word/half accesses as errors.
module dmem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_dm_ena,
   input  logic        i_dm_r,
   input  logic        i_dm_w,
   input  logic [1:0]  i_dm_sel,
   input  logic [31:0] i_dm_addr,
   input  logic [31:0] i_dm_wdata,
   output logic [31:0] o_dm_rdata,
   output logic        o_dm_ready,
   output logic        o_dm_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic          r_err;

   logic [31:0]   w_off;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic          w_misalign;
   logic          w_err;
   logic [31:0]   w_rword;
   logic [31:0]   w_rsel;
   logic [3:0]    w_be;
   logic [31:0]   w_wlanes;
   logic          w_commit;
   logic          w_we;

   assign w_off      = i_dm_addr - ADDR_BASE;
   assign w_in_range = w_off < 32'(4 * DEPTH_WORDS);
   assign w_idx      = w_off[AW+1:2];
   assign w_lane     = i_dm_addr[1:0];

`ifdef DMEM_MISALIGN_EN
   assign w_misalign = ((i_dm_sel == 2'b11) && (w_lane != 2'b00)) ||
                       ((i_dm_sel == 2'b01) && w_lane[0]);
`else
   // Word selection ignores the lane and half selection only looks at lane[1].
   assign w_misalign = 1'b0;
`endif

   assign w_err   = ~w_in_range | (i_dm_sel == 2'b10) | w_misalign;
   assign w_rword = r_mem[w_idx];

   always_comb begin
      w_rsel   = '0;
      w_be     = '0;
      w_wlanes = '0;
      case (i_dm_sel)
         2'b11: begin
            w_rsel   = w_rword;
            w_be     = 4'b1111;
            w_wlanes = i_dm_wdata;
         end
         2'b01: begin
            w_rsel   = {16'h0, (w_lane[1] ? w_rword[31:16] : w_rword[15:0])};
            w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{i_dm_wdata[15:0]}};
         end
         2'b00: begin
            w_rsel   = {24'h0, w_rword[8*w_lane +: 8]};
            w_be     = 4'b0001 << w_lane;
            w_wlanes = {4{i_dm_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   // Read path is combinational; with r and w both set it shows the pre-write word.
   assign o_dm_rdata = (i_dm_ena & i_dm_r & ~w_err) ? w_rsel : 32'h0;

   generate
      if (WAIT_CYCLES == 0) begin : g_nowait
         assign w_commit   = i_dm_ena & i_rst;
         assign o_dm_ready = i_dm_ena;
      end else begin : g_wait
         localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

         state_t        r_state;
         logic [CW-1:0] r_cnt;
         logic          r_ready;

         always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_ready <= 1'b0;
            end else begin
               r_ready <= 1'b0;
               case (r_state)
                  S_IDLE: begin
                     if (i_dm_ena) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CW'(WAIT_CYCLES - 1);
                     end
                  end
                  S_WAIT: begin
                     if (!i_dm_ena) begin
                        r_state <= S_IDLE;
                     end else if (r_cnt == '0) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt - 1'b1;
                     end
                  end
                  default: r_state <= S_IDLE;
               endcase
            end
         end

         // A request withdrawn during RESP neither completes nor reports ready.
         assign w_commit   = (r_state == S_RESP) & i_dm_ena & i_rst;
         assign o_dm_ready = r_ready & i_dm_ena;
      end
   endgenerate

   assign w_we = w_commit & i_dm_w & ~w_err;

   always_ff @(posedge i_clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_err <= 1'b0;
      else if (w_commit & w_err) r_err <= 1'b1;
   end

   assign o_dm_err = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: same-cycle (N=0) and wait-state (N=2, N=3) instances.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena0, ena2, ena3;
   logic        r, w;
   logic [1:0]  sel;
   logic [31:0] addr, wdata;
   logic [31:0] rd0, rd2, rd3;
   logic        rdy0, rdy2, rdy3;
   logic        err0, err2, err3;

   int vectors     = 0;
   int miscompares = 0;

`ifdef DMEM_MISALIGN_EN
   localparam logic [31:0] MIS_RD  = 32'h0000_0000;
   localparam logic        MIS_ERR = 1'b1;
`else
   localparam logic [31:0] MIS_RD  = 32'h0000_BEEF;
   localparam logic        MIS_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   dmem_responder #(.WAIT_CYCLES(0)) dut0 (
      .i_clk(clk), .i_rst(rst_n), .i_dm_ena(ena0), .i_dm_r(r), .i_dm_w(w), .i_dm_sel(sel),
      .i_dm_addr(addr), .i_dm_wdata(wdata), .o_dm_rdata(rd0), .o_dm_ready(rdy0), .o_dm_err(err0));
   dmem_responder #(.WAIT_CYCLES(2)) dut2 (
      .i_clk(clk), .i_rst(rst_n), .i_dm_ena(ena2), .i_dm_r(r), .i_dm_w(w), .i_dm_sel(sel),
      .i_dm_addr(addr), .i_dm_wdata(wdata), .o_dm_rdata(rd2), .o_dm_ready(rdy2), .o_dm_err(err2));
   dmem_responder #(.WAIT_CYCLES(3)) dut3 (
      .i_clk(clk), .i_rst(rst_n), .i_dm_ena(ena3), .i_dm_r(r), .i_dm_w(w), .i_dm_sel(sel),
      .i_dm_addr(addr), .i_dm_wdata(wdata), .o_dm_rdata(rd3), .o_dm_ready(rdy3), .o_dm_err(err3));

   task automatic drv(input logic rr, input logic ww, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d);
      r = rr; w = ww; sel = s; addr = a; wdata = d;
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL rst_rdy0: got %b expected 0", rdy0); end
      vectors++; if (rdy2 !== 1'b0) begin miscompares++; $display("FAIL rst_rdy2: got %b expected 0", rdy2); end
      vectors++; if (rdy3 !== 1'b0) begin miscompares++; $display("FAIL rst_rdy3: got %b expected 0", rdy3); end
      vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL rst_err0: got %b expected 0", err0); end
      vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL rst_err2: got %b expected 0", err2); end
      vectors++; if (err3 !== 1'b0) begin miscompares++; $display("FAIL rst_err3: got %b expected 0", err3); end
      vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL rst_rdata0: got %h expected 0", rd0); end
   endtask

   task automatic test_word();
      @(posedge clk); #1 ena0 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0004, 32'hDEAD_BEEF);
      #1;
      vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL word_wr_ready: got %b expected 1", rdy0); end
      @(posedge clk); #1 drv(1'b1, 1'b0, 2'b11, 32'h1001_0004, 32'h0);
      #1;
      vectors++; if (rd0 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL word_rd: got %h expected deadbeef", rd0); end
      vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL word_rd_ready: got %b expected 1", rdy0); end
      ena0 = 1'b0; #1;
      vectors++; if (rdy0 !== 1'b0) begin miscompares++; $display("FAIL idle_ready: got %b expected 0", rdy0); end
      vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL idle_rdata: got %h expected 0", rd0); end
   endtask

   task automatic test_lanes();
      @(posedge clk); #1 ena0 = 1'b1; drv(1'b0, 1'b1, 2'b00, 32'h1001_0006, 32'hFFFF_FF55);
      @(posedge clk); #1 drv(1'b1, 1'b0, 2'b00, 32'h1001_0006, 32'h0);
      #1;
      vectors++; if (rd0 !== 32'h0000_0055) begin miscompares++; $display("FAIL byte_rd: got %h expected 00000055", rd0); end
      drv(1'b1, 1'b0, 2'b01, 32'h1001_0004, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0000_BEEF) begin miscompares++; $display("FAIL half_lo_rd: got %h expected 0000beef", rd0); end
      drv(1'b1, 1'b0, 2'b01, 32'h1001_0006, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0000_DE55) begin miscompares++; $display("FAIL half_hi_rd: got %h expected 0000de55", rd0); end
      drv(1'b1, 1'b0, 2'b11, 32'h1001_0004, 32'h0); #1;
      vectors++; if (rd0 !== 32'hDE55_BEEF) begin miscompares++; $display("FAIL merged_word_rd: got %h expected de55beef", rd0); end
      ena0 = 1'b0;
   endtask

   task automatic test_misalign();
      @(posedge clk); #1 ena0 = 1'b1; drv(1'b1, 1'b0, 2'b01, 32'h1001_0005, 32'h0);
      #1;
      vectors++; if (rd0 !== MIS_RD) begin miscompares++; $display("FAIL misalign_rd: got %h expected %h", rd0, MIS_RD); end
      @(posedge clk); #1;
      vectors++; if (err0 !== MIS_ERR) begin miscompares++; $display("FAIL misalign_err: got %b expected %b", err0, MIS_ERR); end
      ena0 = 1'b0;
   endtask

   task automatic test_range();
      pulse_reset();
      vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL range_err_pre: got %b expected 0", err0); end
      @(posedge clk); #1 ena0 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0000, 32'h0BAD_F00D);
      @(posedge clk); #1 drv(1'b0, 1'b1, 2'b11, 32'h1001_1000, 32'h1111_1111);
      #1;
      vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL range_err_early: got %b expected 0", err0); end
      @(posedge clk); #1;
      vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL range_err_set: got %b expected 1", err0); end
      drv(1'b1, 1'b0, 2'b11, 32'h1001_1000, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL range_hi_rd: got %h expected 0", rd0); end
      drv(1'b1, 1'b0, 2'b11, 32'h1000_FFFC, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL range_lo_rd: got %h expected 0", rd0); end
      drv(1'b1, 1'b0, 2'b11, 32'h1001_0000, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL range_no_alias: got %h expected 0badf00d", rd0); end
      drv(1'b0, 1'b1, 2'b11, 32'h1001_0FFC, 32'h600D_CAFE);
      @(posedge clk); #1 drv(1'b1, 1'b0, 2'b11, 32'h1001_0FFC, 32'h0); #1;
      vectors++; if (rd0 !== 32'h600D_CAFE) begin miscompares++; $display("FAIL last_word_rd: got %h expected 600dcafe", rd0); end
      ena0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", err0); end
      pulse_reset();
      vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b expected 0", err0); end
      ena0 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0000, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL ram_kept: got %h expected 0badf00d", rd0); end
      ena0 = 1'b0;
   endtask

   task automatic test_rw_both();
      @(posedge clk); #1 ena0 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0008, 32'hCAFE_F00D);
      @(posedge clk); #1 drv(1'b1, 1'b1, 2'b11, 32'h1001_0008, 32'h0102_0304); #1;
      vectors++; if (rd0 !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rw_prewrite: got %h expected cafef00d", rd0); end
      @(posedge clk); #1 drv(1'b1, 1'b0, 2'b11, 32'h1001_0008, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0102_0304) begin miscompares++; $display("FAIL rw_postwrite: got %h expected 01020304", rd0); end
      ena0 = 1'b0;
   endtask

   task automatic test_reserved();
      @(posedge clk); #1 ena0 = 1'b1; drv(1'b1, 1'b1, 2'b10, 32'h1001_0008, 32'hFFFF_FFFF); #1;
      vectors++; if (rd0 !== 32'h0) begin miscompares++; $display("FAIL sel10_rd: got %h expected 0", rd0); end
      vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL sel10_err_early: got %b expected 0", err0); end
      @(posedge clk); #1;
      vectors++; if (err0 !== 1'b1) begin miscompares++; $display("FAIL sel10_err: got %b expected 1", err0); end
      drv(1'b1, 1'b0, 2'b11, 32'h1001_0008, 32'h0); #1;
      vectors++; if (rd0 !== 32'h0102_0304) begin miscompares++; $display("FAIL sel10_nowrite: got %h expected 01020304", rd0); end
      ena0 = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      bit seen = 1'b0;
      @(posedge clk); #1 ena2 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0008, 32'h1234_5678);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rdy2) seen = 1'b1;
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL n2_wr_timeout: got no ready expected ready"); end
      @(posedge clk); #1 ena2 = 1'b0;
      #1 ena2 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0008, 32'h0); #1;
      vectors++; if (rd2 !== 32'h1234_5678) begin miscompares++; $display("FAIL n2_wr_rd: got %h expected 12345678", rd2); end
      ena2 = 1'b0;
      @(posedge clk); #1 ena2 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0008, 32'hFFFF_FFFF);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b0; #1;
      vectors++; if (rdy2 !== 1'b0) begin miscompares++; $display("FAIL midwait_rst_ready: got %b expected 0", rdy2); end
      vectors++; if (err2 !== 1'b0) begin miscompares++; $display("FAIL midwait_rst_err: got %b expected 0", err2); end
      ena2 = 1'b0; drv(1'b0, 1'b0, 2'b11, 32'h1001_0008, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      #1 ena2 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0008, 32'h0); #1;
      vectors++; if (rd2 !== 32'h1234_5678) begin miscompares++; $display("FAIL midwait_rst_nowrite: got %h expected 12345678", rd2); end
      vectors++; if (rdy2 !== 1'b0) begin miscompares++; $display("FAIL midwait_rst_idle: got %b expected 0", rdy2); end
      ena2 = 1'b0;
   endtask

   task automatic test_wait_timing();
      @(posedge clk); #1 ena3 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0004, 32'h0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         vectors++;
         if (rdy3 !== (c == 5)) begin miscompares++; $display("FAIL n3_ready_c%0d: got %b expected %b", c, rdy3, (c == 5)); end
      end
      ena3 = 1'b0;
      @(posedge clk); #1 ena3 = 1'b1;
      @(negedge clk);
      vectors++; if (rdy3 !== 1'b0) begin miscompares++; $display("FAIL abort_c1: got %b expected 0", rdy3); end
      @(posedge clk); #1 ena3 = 1'b0;
      @(negedge clk);
      vectors++; if (rdy3 !== 1'b0) begin miscompares++; $display("FAIL abort_c2: got %b expected 0", rdy3); end
      @(posedge clk); #1 ena3 = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         vectors++;
         if (rdy3 !== (c == 5)) begin miscompares++; $display("FAIL reissue_c%0d: got %b expected %b", c, rdy3, (c == 5)); end
      end
      ena3 = 1'b0;
   endtask

   task automatic test_wait_write();
      bit seen = 1'b0;
      @(posedge clk); #1 ena3 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0010, 32'hA5A5_A5A5);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rdy3) seen = 1'b1;
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL n3_wr_timeout: got no ready expected ready"); end
      @(posedge clk); #1 ena3 = 1'b0;
      #1 ena3 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0010, 32'h0); #1;
      vectors++; if (rd3 !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL n3_wr_rd: got %h expected a5a5a5a5", rd3); end
      ena3 = 1'b0;
      @(posedge clk); #1 ena3 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0010, 32'h5A5A_5A5A);
      @(posedge clk); @(posedge clk); #1 ena3 = 1'b0;
      @(posedge clk); #1 ena3 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0010, 32'h0); #1;
      vectors++; if (rd3 !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL abort_wait_nowrite: got %h expected a5a5a5a5", rd3); end
      ena3 = 1'b0;
      seen = 1'b0;
      @(posedge clk); #1 ena3 = 1'b1; drv(1'b0, 1'b1, 2'b11, 32'h1001_0010, 32'h3C3C_3C3C);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rdy3) seen = 1'b1;
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL n3_resp_timeout: got no ready expected ready"); end
      #1 ena3 = 1'b0; #1;
      vectors++; if (rdy3 !== 1'b0) begin miscompares++; $display("FAIL abort_resp_ready: got %b expected 0", rdy3); end
      @(posedge clk); #1 ena3 = 1'b1; drv(1'b1, 1'b0, 2'b11, 32'h1001_0010, 32'h0); #1;
      vectors++; if (rd3 !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL abort_resp_nowrite: got %h expected a5a5a5a5", rd3); end
      ena3 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; ena0 = 1'b0; ena2 = 1'b0; ena3 = 1'b0;
      drv(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_word();
      test_lanes();
      test_misalign();
      test_range();
      test_rw_both();
      test_reserved();
      test_reset_mid_wait();
      test_wait_timing();
      test_wait_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
